ex_mem_stage: RTL and testbench

EX/MEM pipeline stage of the RISC-V core: registers the execute-stage result bundle and presents it to the memory stage through a valid/ready handshake. A two-entry skid buffer absorbs data-memory wait states without a combinational ready path back into EX. The head entry's destination tag (rd, write-back, load, float) is exported directly to the MEM forwarding unit and to the hazard unit.

---
 rtl/riscv_pipe_pkg.sv | 26 ++
 rtl/pipe_skid2.sv | 64 ++++++
 rtl/ex_mem_stage.sv | 74 +++++++
 tb/tb_ex_mem_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline types; the entry carries an fp bit when EX_MEM_FLOAT_EN is defined
package riscv_pipe_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;
  typedef struct packed {
`ifdef EX_MEM_FLOAT_EN
    logic            fp;
`endif
    logic [4:0]      rd;
    logic            wb;
    logic            load;
    logic            store;
    logic [2:0]      funct3;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pc;
  } ex_mem_entry_t;
  function automatic ex_mem_entry_t ctrl_mask();
    ex_mem_entry_t m;
    m = '0;
    m.wb = 1'b1;
    m.load = 1'b1;
    m.store = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/pipe_skid2.sv
// pipe_skid2: two-entry skid buffer with registered in_ready; flush clears CLR_MASK bits of both entries
import riscv_pipe_pkg::*;
module pipe_skid2 #(
  parameter int W = 8,
  parameter logic [W-1:0] CLR_MASK = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  skid_state_e state_q, state_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic ready_q, in_fire, out_fire;
  assign in_fire = in_valid & ready_q;
  assign out_fire = (state_q != EMPTY) & out_ready;
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      EMPTY: if (in_fire) begin
        state_d = ONE;
        main_d = in_data;
      end
      ONE: begin
        state_d = (in_fire & !out_fire) ? TWO : (!in_fire & out_fire) ? EMPTY : ONE;
        main_d = (in_fire & out_fire) ? in_data : main_q;
        skid_d = (in_fire & !out_fire) ? in_data : skid_q;
      end
      TWO: if (out_fire) begin
        state_d = ONE;
        main_d = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d = main_q & ~CLR_MASK;
      skid_d = skid_q & ~CLR_MASK;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != TWO);
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
  assign in_ready = ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data = main_q;
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM register over a two-entry skid buffer with forwarding decode
// EX_MEM_FLOAT_EN adds the float destination bit and its ports
import riscv_pipe_pkg::*;
module ex_mem_stage (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_rd,
  input  logic            ex_wb,
  input  logic            ex_load,
  input  logic            ex_store,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [XLEN-1:0] ex_pc,
`ifdef EX_MEM_FLOAT_EN
  input  logic            ex_fp_rd,
  output logic            mem_fp_rd,
  output logic            fwd_fp,
`endif
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [4:0]      mem_rd,
  output logic            mem_wb,
  output logic            mem_load,
  output logic            mem_store,
  output logic [2:0]      mem_funct3,
  output logic [XLEN-1:0] mem_result,
  output logic [XLEN-1:0] mem_store_data,
  output logic [XLEN-1:0] mem_pc,
  output logic [4:0]      fwd_rd,
  output logic            fwd_wb,
  output logic            fwd_load
);
  ex_mem_entry_t in_e, out_e;
  always_comb begin
    in_e = '0;
    in_e.rd = ex_rd;
    in_e.load = ex_load;
    in_e.store = ex_store;
    in_e.funct3 = ex_funct3;
    in_e.result = ex_result;
    in_e.store_data = ex_store_data;
    in_e.pc = ex_pc;
`ifdef EX_MEM_FLOAT_EN
    in_e.fp = ex_fp_rd;
    in_e.wb = ex_wb & (ex_fp_rd | (ex_rd != 5'd0));
`else
    in_e.wb = ex_wb & (ex_rd != 5'd0);
`endif
  end
  pipe_skid2 #(.W($bits(ex_mem_entry_t)), .CLR_MASK(ctrl_mask())) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(ex_valid), .in_ready(ex_ready), .in_data(in_e),
    .out_valid(mem_valid), .out_ready(mem_ready), .out_data(out_e)
  );
  assign mem_rd = out_e.rd;
  assign mem_wb = out_e.wb;
  assign mem_load = out_e.load;
  assign mem_store = out_e.store;
  assign mem_funct3 = out_e.funct3;
  assign mem_result = out_e.result;
  assign mem_store_data = out_e.store_data;
  assign mem_pc = out_e.pc;
  assign fwd_rd = out_e.rd;
  assign fwd_wb = mem_valid & out_e.wb & !out_e.load;
  assign fwd_load = mem_valid & out_e.load;
`ifdef EX_MEM_FLOAT_EN
  assign mem_fp_rd = out_e.fp;
  assign fwd_fp = out_e.fp;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed checks of streaming, back-pressure, forwarding, flush and reset
module tb_ex_mem_stage;
  logic clk = 0, rst_n, flush, ex_valid, ex_ready, ex_wb, ex_load, ex_store;
  logic [4:0] ex_rd, mem_rd, fwd_rd;
  logic [2:0] ex_funct3, mem_funct3;
  logic [31:0] ex_result, ex_store_data, ex_pc, mem_result, mem_store_data, mem_pc;
  logic mem_valid, mem_ready, mem_wb, mem_load, mem_store, fwd_wb, fwd_load;
`ifdef EX_MEM_FLOAT_EN
  logic ex_fp_rd, mem_fp_rd, fwd_fp;
`endif
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rd(ex_rd), .ex_wb(ex_wb), .ex_load(ex_load), .ex_store(ex_store), .ex_funct3(ex_funct3),
    .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
`ifdef EX_MEM_FLOAT_EN
    .ex_fp_rd(ex_fp_rd), .mem_fp_rd(mem_fp_rd), .fwd_fp(fwd_fp),
`endif
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wb(mem_wb),
    .mem_load(mem_load), .mem_store(mem_store), .mem_funct3(mem_funct3), .mem_result(mem_result),
    .mem_store_data(mem_store_data), .mem_pc(mem_pc), .fwd_rd(fwd_rd), .fwd_wb(fwd_wb),
    .fwd_load(fwd_load)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic send(input logic [31:0] pc, input logic [4:0] rd, input logic wb, input logic ld);
    ex_valid = 1; ex_pc = pc; ex_rd = rd; ex_wb = wb; ex_load = ld;
    ex_result = pc ^ 32'hA5A5_0000; ex_store_data = ~pc;
  endtask
  initial begin
    rst_n = 0; flush = 0; ex_valid = 0; ex_wb = 0; ex_load = 0; ex_store = 0; ex_rd = 0;
    ex_funct3 = 3'd2; ex_result = 0; ex_store_data = 0; ex_pc = 0; mem_ready = 0;
`ifdef EX_MEM_FLOAT_EN
    ex_fp_rd = 0;
`endif
    step();
    chk("rst_ex_ready", 32'(ex_ready), 1);
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_mem_pc", mem_pc, 0);
    chk("rst_fwd_wb", 32'(fwd_wb), 0);
    rst_n = 1;
    mem_ready = 1;
    for (int i = 0; i < 8; i++) begin
      send(32'h200 + 32'(4 * i), 5'(i + 1), 1, 0);
      step();
      chk("stream_valid", 32'(mem_valid), 1);
      chk("stream_pc", mem_pc, 32'h200 + 32'(4 * i));
      chk("stream_ready", 32'(ex_ready), 1);
    end
    chk("stream_result", mem_result, 32'h21C ^ 32'hA5A5_0000);
    ex_valid = 0;
    step();
    chk("stream_drain", 32'(mem_valid), 0);
    mem_ready = 0;
    send(32'h100, 5'd1, 1, 0);
    step();
    chk("bp_pc0", mem_pc, 32'h100);
    send(32'h104, 5'd2, 1, 0);
    step();
    chk("bp_ready_low", 32'(ex_ready), 0);
    chk("bp_hold0", mem_pc, 32'h100);
    send(32'h108, 5'd3, 1, 0);
    step();
    chk("bp_still_low", 32'(ex_ready), 0);
    chk("bp_hold1", mem_pc, 32'h100);
    mem_ready = 1;
    step();
    chk("bp_pc1", mem_pc, 32'h104);
    chk("bp_ready_back", 32'(ex_ready), 1);
    step();
    chk("bp_pc2", mem_pc, 32'h108);
    ex_valid = 0;
    step();
    chk("bp_drain", 32'(mem_valid), 0);
    mem_ready = 0;
    send(32'h400, 5'd5, 1, 0);
    step();
    ex_valid = 0;
    chk("fwd_wb_alu", 32'(fwd_wb), 1);
    chk("fwd_rd_alu", 32'(fwd_rd), 5);
    chk("fwd_load_alu", 32'(fwd_load), 0);
    mem_ready = 1;
    step();
    mem_ready = 0;
    send(32'h404, 5'd5, 1, 1);
    step();
    ex_valid = 0;
    chk("fwd_wb_load", 32'(fwd_wb), 0);
    chk("fwd_load_load", 32'(fwd_load), 1);
    mem_ready = 1;
    step();
    mem_ready = 0;
    send(32'h408, 5'd0, 1, 0);
    step();
    ex_valid = 0;
    chk("x0_valid", 32'(mem_valid), 1);
    chk("x0_fwd_wb", 32'(fwd_wb), 0);
    chk("x0_mem_wb", 32'(mem_wb), 0);
    mem_ready = 1;
    step();
    mem_ready = 0;
    send(32'h40C, 5'd0, 1, 0);
`ifdef EX_MEM_FLOAT_EN
    ex_fp_rd = 1;
`endif
    step();
    ex_valid = 0;
`ifdef EX_MEM_FLOAT_EN
    ex_fp_rd = 0;
    chk("f0_fwd_wb", 32'(fwd_wb), 1);
    chk("f0_fwd_fp", 32'(fwd_fp), 1);
`else
    chk("f0_fwd_wb", 32'(fwd_wb), 0);
`endif
    mem_ready = 1;
    step();
    mem_ready = 0;
    send(32'h300, 5'd4, 1, 0);
    step();
    send(32'h304, 5'd6, 1, 1);
    step();
    chk("fl_two", 32'(ex_ready), 0);
    send(32'h308, 5'd7, 1, 0);
    flush = 1;
    step();
    flush = 0;
    ex_valid = 0;
    chk("fl_valid", 32'(mem_valid), 0);
    chk("fl_ready", 32'(ex_ready), 1);
    chk("fl_wb_clr", 32'(mem_wb), 0);
    chk("fl_fwd_load", 32'(fwd_load), 0);
    mem_ready = 1;
    step();
    step();
    chk("fl_no_ghost", 32'(mem_valid), 0);
    send(32'h30C, 5'd8, 1, 0);
    step();
    ex_valid = 0;
    chk("fl_next_pc", mem_pc, 32'h30C);
    step();
    mem_ready = 0;
    send(32'h500, 5'd7, 1, 1);
    step();
    ex_valid = 0;
    chk("rst1_valid", 32'(mem_valid), 1);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("rst1_mem_valid", 32'(mem_valid), 0);
    chk("rst1_ex_ready", 32'(ex_ready), 1);
    chk("rst1_fwd_wb", 32'(fwd_wb), 0);
    chk("rst1_fwd_load", 32'(fwd_load), 0);
    chk("rst1_fwd_rd", 32'(fwd_rd), 0);
    chk("rst1_mem_pc", mem_pc, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
